// File: rtl/demux4_buf.sv
// demux4_buf: registered 1-to-4 demultiplexer with a valid/ready handshake on each side.
// One WIDTH-bit word per cycle is steered by in_sel into one of four single-entry holding
// registers. Each holding register is drained independently by its own consumer.
//
// Ports:
//   clk                   single clock, rising-edge state updates
//   rst_n                 asynchronous active-low reset
//   clr                   synchronous clear of all buffered words (data registers kept)
//   in_valid/in_ready     input handshake; in_ready is combinational
//   in_sel                destination channel 0..3
//   in_data               input word
//   out_valid[k]          channel k holding register is full
//   out_ready[k]          consumer k takes the word this cycle
//   out_data0..out_data3  channel holding registers
//   busy                  any channel full
module demux4_buf #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3,
  output logic             busy
);

  logic [3:0]            r_valid;
  logic [3:0]            w_valid_d;
  logic [3:0][WIDTH-1:0] r_data;
  logic [3:0]            w_load;
  logic [3:0]            w_drain;
  logic                  w_sel_full;
  logic                  w_sel_taken;
  logic                  w_accept;

  // Readiness looks only at the selected channel, so a full channel never stalls traffic
  // headed elsewhere. A same-cycle drain frees the slot, giving one word per cycle per channel.
  assign w_sel_full  = r_valid[in_sel];
  assign w_sel_taken = out_ready[in_sel];
  assign in_ready    = !clr && (!w_sel_full || w_sel_taken);
  assign w_accept    = in_valid && in_ready;

  // out_ready on an empty channel is masked here, so it cannot disturb state.
  assign w_drain = r_valid & out_ready;

  always_comb begin
    w_load = 4'b0000;
    if (w_accept) begin
      unique case (in_sel)
        2'd0:    w_load = 4'b0001;
        2'd1:    w_load = 4'b0010;
        2'd2:    w_load = 4'b0100;
        2'd3:    w_load = 4'b1000;
        default: w_load = 4'b0000;
      endcase
    end
  end

  // Load after drain so a simultaneous drain+accept on one channel leaves it full.
  // clr overrides both; w_load is already zero under clr because in_ready is low.
  always_comb begin
    w_valid_d = (r_valid & ~w_drain) | w_load;
    if (clr) begin
      w_valid_d = 4'b0000;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 4'b0000;
    end else begin
      r_valid <= w_valid_d;
    end
  end

  // Data registers only change on a load, which keeps them stable under backpressure and
  // leaves the last word visible after a drain or clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (w_load[k]) begin
          r_data[k] <= in_data;
        end
      end
    end
  end

  assign out_valid = r_valid;
  assign out_data0 = r_data[0];
  assign out_data1 = r_data[1];
  assign out_data2 = r_data[2];
  assign out_data3 = r_data[3];
  assign busy      = |r_valid;

endmodule
